// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding, cascade seed values and the default operand width.
package serial_mag_comp_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Seed of the cascade: "equal so far", neither greater nor less.
   localparam logic G_INIT = 1'b0;
   localparam logic E_INIT = 1'b1;
   localparam logic L_INIT = 1'b0;

endpackage

// File: rtl/serial_mag_comp_if.sv
// Request/result bundle of the serial magnitude comparator.
// master: requester (drives start and operands); slave: the comparator.
interface serial_mag_comp_if
   import serial_mag_comp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (output start, a_in, b_in,
                   input  busy, done, gt, eq, lt);

   modport slave  (input  start, a_in, b_in,
                   output busy, done, gt, eq, lt);
endinterface

// File: rtl/Comp_1bit.sv
// One-bit cascade magnitude comparator cell. The gin/ein/lin inputs carry the
// verdict of the more significant bits; this bit only matters while those
// bits are still equal.
module Comp_1bit (
   input  logic a,
   input  logic b,
   input  logic gin,
   input  logic ein,
   input  logic lin,
   output logic gout,
   output logic eout,
   output logic lout
);
   assign gout = gin | (ein & a & ~b);
   assign eout = ein & ~(a ^ b);
   assign lout = lin | (ein & ~a & b);
endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator. Operands are captured on an accepted
// start and streamed MSB-first through a single Comp_1bit cell whose
// outputs are registered and fed back as the next cascade inputs.
// Optional build macro: SERIAL_COMP_EARLY_EXIT_EN -- finish as soon as the
// first differing bit decides the result instead of always taking WIDTH
// cycles.
module serial_mag_comp
   import serial_mag_comp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst,
   serial_mag_comp_if.slave     bus
);
   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic               g_q, g_d;
   logic               e_q, e_d;
   logic               l_q, l_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               gt_q, gt_d;
   logic               eq_q, eq_d;
   logic               lt_q, lt_d;

   logic               cell_g;
   logic               cell_e;
   logic               cell_l;
   logic               finish;

   Comp_1bit u_cell (
      .a    (sa_q[WIDTH-1]),
      .b    (sb_q[WIDTH-1]),
      .gin  (g_q),
      .ein  (e_q),
      .lin  (l_q),
      .gout (cell_g),
      .eout (cell_e),
      .lout (cell_l)
   );

   // Last compare step: the final bit, or (early exit) any bit that differs.
`ifdef SERIAL_COMP_EARLY_EXIT_EN
   assign finish = (cnt_q == '0) || !cell_e;
`else
   assign finish = (cnt_q == '0);
`endif

   // Next-state and datapath update for load, shift and completion.
   always_comb begin
      // NOTE: every *_d gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      g_d     = g_q;
      e_d     = e_q;
      l_d     = l_q;
      cnt_d   = cnt_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d = SHIFT;
               sa_d    = bus.a_in;
               sb_d    = bus.b_in;
               g_d     = G_INIT;
               e_d     = E_INIT;
               l_d     = L_INIT;
               cnt_d   = CNT_W'(WIDTH - 1);
            end
         end
         SHIFT: begin
            g_d   = cell_g;
            e_d   = cell_e;
            l_d   = cell_l;
            sa_d  = sa_q << 1;
            sb_d  = sb_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (finish) begin
               gt_d    = cell_g;
               eq_d    = cell_e;
               lt_d    = cell_l;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         g_q     <= 1'b0;
         e_q     <= 1'b0;
         l_q     <= 1'b0;
         cnt_q   <= '0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         g_q     <= g_d;
         e_q     <= e_d;
         l_q     <= l_d;
         cnt_q   <= cnt_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.gt   = gt_q;
   assign bus.eq   = eq_q;
   assign bus.lt   = lt_q;

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
Bit-serial magnitude comparator that produces greater, equal and less flags for two WIDTH-bit unsigned operands. It loads both operands on a start pulse and feeds them MSB-first through one 1-bit cascade comparator cell. Each cycle it registers the cell's gout/eout/lout outputs and feeds them back into gin/ein/lin. It sits upstream of consumers that need a registered compare result with a done strobe, and trades latency for area against a WIDTH-cell ripple chain.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
a_in  input  WIDTH  operand A, unsigned; captured on an accepted start
b_in  input  WIDTH  operand B, unsigned; captured on an accepted start
busy  output  1  high while the comparison is in progress (SHIFT state)
done  output  1  one-cycle strobe; result valid
gt  output  1  registered A>B
eq  output  1  registered A==B
lt  output  1  registered A<B

Behaviour:
- The clock is clk. Reset rst is synchronous, active-high, and takes priority over everything. While rst is high at an edge: state goes to IDLE; busy, done, gt, eq and lt all go to 0; the shift registers and bit counter clear.
- States:
  - IDLE: on start, go to SHIFT.
  - SHIFT: compare one bit per cycle; after the WIDTH-th bit, go to DONE.
  - DONE: on start, go to SHIFT; otherwise go to IDLE.
- Accepted start (in IDLE or DONE):
  - load sa<=a_in, sb<=b_in;
  - set cascade regs to g=0, e=1, l=0;
  - set cnt=WIDTH-1.
- Each SHIFT edge:
  - drive the cell with a=sa[MSB], b=sb[MSB], gin=g, ein=e, lin=l;
  - register the cell outputs into g/e/l;
  - shift sa and sb left by one;
  - decrement cnt.
- At the SHIFT edge where cnt==0:
  - copy the cell outputs into gt/eq/lt;
  - go to DONE.
- busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state, so neither has a combinational path from the inputs.
- Latency: start accepted at edge k; result updated and done high WIDTH edges later (edge k+WIDTH), for one cycle.
- gt/eq/lt change only at completion and hold between operations. After any completion, exactly one of them is high. Before the first completion after reset, all three are 0.
- start while busy is ignored; the operation in flight is unaffected.
- start in the DONE cycle is accepted back-to-back. done stays a 1-cycle strobe and the new result follows WIDTH cycles later.
- a_in/b_in are sampled only on an accepted start; changes at other times have no effect.
- Reset mid-operation aborts it; no done is produced for the aborted operation.

Optional Feature:
SERIAL_COMP_EARLY_EXIT_EN
- Defined: in SHIFT, if the cell's eout is 0 (result decided), copy the result into gt/eq/lt and go to DONE on that edge, regardless of cnt. Latency is 1..WIDTH cycles: the index of the first differing bit from the MSB, plus 1. Equal operands still take WIDTH cycles.
- Undefined: latency is always exactly WIDTH cycles. There is no data-dependent timing.

Decomposition:
- Shared package/header holds:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - cascade init constants G_INIT=0, E_INIT=1, L_INIT=0;
  - default WIDTH.
- One sub-module: Comp_1bit, the team's existing 1-bit cascade comparator cell. It has ports a, b, gin, ein, lin, gout, eout, lout and is instantiated once, unmodified.
- Counter width is $clog2(WIDTH), computed locally.

Test Plan:
- WIDTH=8, a_in=8'hA5, b_in=8'h5A, start pulse -> busy high for 8 cycles, done high exactly 8 edges after start, gt=1 eq=0 lt=0.
- a_in=b_in=8'h3C -> eq=1 gt=0 lt=0 after 8 cycles, with or without the macro.
- a_in=8'h00, b_in=8'hFF, then a new start on the DONE cycle with a_in=8'hFF, b_in=8'hFE -> first done gives lt=1; second done follows 8 cycles later with gt=1.
- start re-pulsed with different operands 3 cycles into an operation -> ignored; original result and timing unchanged.
- rst asserted 4 cycles into an operation -> next cycle busy=done=gt=eq=lt=0 and no done strobe; a following start completes normally.
- With SERIAL_COMP_EARLY_EXIT_EN: a_in=8'h80, b_in=8'h00 -> done 1 edge after start, gt=1. a_in=8'h12, b_in=8'h13 -> done after 8 edges, lt=1. Without the macro, both take 8 cycles.
